mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
Memory stage of the ARM pipeline. It consumes the EX/MEM register outputs (WB/MEM enables, ALU result used as the address, Val_Rm used as store data, destination register). Each 32-bit load/store is executed against an external 16-bit asynchronous SRAM as two half-word phases with programmable wait states. While the access runs, the block freezes the pipeline through `ready`. The MEM/WB pipeline register is embedded in this block.

Parameters:
- DATA_LEN, 32, CPU data width.
- ADDRESS_LEN_REG_FILE, 4, destination register index width.
- SRAM_DATA_LEN, 16, SRAM data bus width. Fixed at DATA_LEN/2.
- SRAM_ADDR_LEN, 18, SRAM half-word address width.
- WAIT_CYCLES, 2, cycles per half-word phase. Legal values are 2 or more.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM half-word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits from the EX/MEM register.
- ALU_Res_in  in  DATA_LEN  byte address, or ALU result for non-memory ops.
- Val_Rm_in  in  DATA_LEN  store data.
- Dest_in  in  ADDRESS_LEN_REG_FILE  destination register.
- ready  out  1  0 = freeze every upstream pipeline register and the PC.
- WB_EN, MEM_R_EN  out  1 each  MEM/WB register outputs.
- ALU_Res, Mem_Data  out  DATA_LEN each  MEM/WB register outputs.
- Dest  out  ADDRESS_LEN_REG_FILE  MEM/WB register output.
- SRAM_ADDR  out  SRAM_ADDR_LEN  SRAM half-word address.
- SRAM_DQ_out  out  SRAM_DATA_LEN  write data.
- SRAM_DQ_oe  out  1  1 = drive the SRAM data bus.
- SRAM_DQ_in  in  SRAM_DATA_LEN  read data.
- SRAM_WE_N  out  1  active-low write strobe.

Behaviour:
- Request: `req = MEM_R_EN_in | MEM_W_EN_in`. If both are set, the access is a read and no write strobe is issued.
- Address:
  - `off = ALU_Res_in - BASE_ADDR`, computed modulo 2^DATA_LEN.
  - `word = off >> 2`.
  - Low half-word address = `{word, 1'b0}`, high half-word address = `{word, 1'b1}`.
  - Both are truncated to SRAM_ADDR_LEN bits. There is no range check; `off[1:0]` is ignored.
- FSM states and transitions:
  - IDLE: stays in IDLE while `req=0`. Goes to LOW when `req=1`, loading `cnt=0`.
  - LOW: lasts WAIT_CYCLES cycles, with `cnt` counting 0..WAIT_CYCLES-1. On its last cycle it goes to HIGH and reloads `cnt=0`.
  - HIGH: same length as LOW. On its last cycle it goes to DONE.
  - DONE: lasts one cycle, then goes to IDLE.
- `ready` is combinational: `ready = (state==IDLE & ~req) | (state==DONE)`.
  - A memory op therefore holds `ready=0` for 2*WAIT_CYCLES+1 cycles, counting the IDLE detect cycle.
  - With the default WAIT_CYCLES=2 that is 5 frozen cycles, and the access occupies 6 cycles in total.
- Upstream inputs stay stable while `ready=0`; the pipeline freeze guarantees this.
- SRAM drive:
  - `SRAM_ADDR` = low address in LOW, high address in HIGH, 0 otherwise.
  - Writes: `SRAM_DQ_oe=1` in LOW and HIGH. `SRAM_DQ_out = Val_Rm_in[15:0]` in LOW and `Val_Rm_in[31:16]` in HIGH.
  - Writes: `SRAM_WE_N=0` on every LOW/HIGH cycle except the last cycle of each phase, which gives address/data hold. `SRAM_WE_N=1` everywhere else.
  - Reads: `SRAM_DQ_oe=0` and `SRAM_WE_N=1` at all times.
  - In IDLE and DONE: `SRAM_DQ_oe=0`, `SRAM_DQ_out=0`, `SRAM_WE_N=1`.
- Read capture:
  - On the last LOW cycle, `SRAM_DQ_in` is registered into `lo_buf`.
  - On the last HIGH cycle, `SRAM_DQ_in` is registered into `hi_buf`.
  - Both buffers are registered for writes too, but the values are unused.
- MEM/WB register:
  - Loads on a clock edge where `ready=1`: `WB_EN<=WB_EN_in`, `MEM_R_EN<=MEM_R_EN_in`, `ALU_Res<=ALU_Res_in`, `Dest<=Dest_in`.
  - `Mem_Data` loads `{hi_buf, lo_buf}` only when `MEM_R_EN_in=1`; otherwise it holds.
  - When `ready=0`, every MEM/WB output holds.
- Non-memory op (`req=0` in IDLE): pure one-cycle pass-through; the FSM never leaves IDLE.
- Back-to-back memory ops: after DONE the FSM returns to IDLE. The next op is detected in that IDLE cycle, so there is no extra bubble beyond the IDLE detect cycle.
- Reset (`rst=0`, asynchronous, may arrive at any time including mid-phase):
  - `state=IDLE`, `cnt=0`, `lo_buf=hi_buf=0`.
  - All MEM/WB outputs 0.
  - `SRAM_WE_N=1`, `SRAM_DQ_oe=0`, `SRAM_ADDR=0`, `SRAM_DQ_out=0`.
  - `ready` follows its combinational rule in IDLE.
  - An aborted write may leave SRAM partially updated; this is accepted.

Test Plan:
- Reset: hold `rst=0` with random inputs -> all MEM/WB outputs 0, `SRAM_WE_N=1`, `SRAM_DQ_oe=0`. With `req=0`, `ready=1`.
- Store: `MEM_W_EN_in=1`, `ALU_Res_in=1032`, `Val_Rm_in=0x1234ABCD`, WAIT_CYCLES=2 ->
  - `SRAM_ADDR=4`, `DQ_out=0xABCD` for 2 cycles, then `SRAM_ADDR=5`, `DQ_out=0x1234` for 2 cycles.
  - `WE_N` pattern 0,1,0,1.
  - `ready` low for 5 cycles, high in DONE; SRAM model holds mem[4]=0xABCD, mem[5]=0x1234.
- Load: `MEM_R_EN_in=1`, `WB_EN_in=1`, `ALU_Res_in=1032`, `Dest_in=7` after the store -> after 6 cycles `Mem_Data=0x1234ABCD`, `WB_EN=1`, `MEM_R_EN=1`, `Dest=7`, `ALU_Res=1032`, and `WE_N` stays 1.
- Non-memory op: `WB_EN_in=1`, `ALU_Res_in=0x55`, `Dest_in=3` -> `ready` stays 1 and the outputs update on the next edge; `SRAM_WE_N=1`, `SRAM_DQ_oe=0`.
- Both enables: `MEM_R_EN_in=MEM_W_EN_in=1` -> read timing, `WE_N` never 0, SRAM contents unchanged.
- Async reset mid-op: assert `rst=0` in the first HIGH cycle of a store -> outputs clear immediately, FSM in IDLE, mem[5] untouched. A following load executes the full 6-cycle sequence.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - ARM memory stage: 32-bit access over 16-bit async SRAM, with MEM/WB register
module mem_stage_sram_ctrl #(
    parameter int DATA_LEN             = 32,
    parameter int ADDRESS_LEN_REG_FILE = 4,
    parameter int SRAM_DATA_LEN        = DATA_LEN / 2,
    parameter int SRAM_ADDR_LEN        = 18,
    parameter int WAIT_CYCLES          = 2,
    parameter int BASE_ADDR            = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            WB_EN_in,
    input  logic                            MEM_R_EN_in,
    input  logic                            MEM_W_EN_in,
    input  logic [DATA_LEN-1:0]             ALU_Res_in,
    input  logic [DATA_LEN-1:0]             Val_Rm_in,
    input  logic [ADDRESS_LEN_REG_FILE-1:0] Dest_in,
    output logic                            ready,
    output logic                            WB_EN,
    output logic                            MEM_R_EN,
    output logic [DATA_LEN-1:0]             ALU_Res,
    output logic [DATA_LEN-1:0]             Mem_Data,
    output logic [ADDRESS_LEN_REG_FILE-1:0] Dest,
    output logic [SRAM_ADDR_LEN-1:0]        SRAM_ADDR,
    output logic [SRAM_DATA_LEN-1:0]        SRAM_DQ_out,
    output logic                            SRAM_DQ_oe,
    input  logic [SRAM_DATA_LEN-1:0]        SRAM_DQ_in,
    output logic                            SRAM_WE_N
);

    localparam int CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                   state, next_state;
    logic [CNT_W-1:0]         cnt, next_cnt;
    logic [SRAM_DATA_LEN-1:0] lo_buf, hi_buf;
    logic                     req, is_write, last, next_busy;
    logic [DATA_LEN-1:0]      off, word;
    logic [SRAM_ADDR_LEN-1:0] lo_addr, hi_addr;

    assign req       = MEM_R_EN_in | MEM_W_EN_in;
    assign is_write  = MEM_W_EN_in & ~MEM_R_EN_in;
    assign last      = (cnt == CNT_LAST);
    assign off       = ALU_Res_in - DATA_LEN'(BASE_ADDR);
    assign word      = off >> 2;
    assign lo_addr   = SRAM_ADDR_LEN'(word << 1);
    assign hi_addr   = SRAM_ADDR_LEN'((word << 1) | DATA_LEN'(1));
    assign ready     = ((state == IDLE) & ~req) | (state == DONE);
    assign next_busy = (next_state == LOW) | (next_state == HIGH);

    always_comb begin
        next_state = state;
        next_cnt   = '0;
        case (state)
            IDLE: next_state = req ? LOW : IDLE;
            LOW: begin
                next_state = last ? HIGH : LOW;
                next_cnt   = last ? '0 : cnt + 1'b1;
            end
            HIGH: begin
                next_state = last ? DONE : HIGH;
                next_cnt   = last ? '0 : cnt + 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // SRAM pins are registered from the next state so they line up with the phase being entered;
    // upstream inputs are frozen while ready=0, so sampling them here is safe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lo_buf      <= '0;
            hi_buf      <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            WB_EN       <= 1'b0;
            MEM_R_EN    <= 1'b0;
            ALU_Res     <= '0;
            Mem_Data    <= '0;
            Dest        <= '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            SRAM_ADDR <= (next_state == LOW)  ? lo_addr :
                         (next_state == HIGH) ? hi_addr : '0;
            SRAM_DQ_oe  <= is_write & next_busy;
            SRAM_DQ_out <= !(is_write & next_busy) ? '0 :
                           (next_state == LOW) ? Val_Rm_in[SRAM_DATA_LEN-1:0]
                                               : Val_Rm_in[DATA_LEN-1:SRAM_DATA_LEN];
            // Strobe released on the final cycle of each phase for address/data hold
            SRAM_WE_N <= ~(is_write & next_busy & (next_cnt != CNT_LAST));
            if (state == LOW && last)
                lo_buf <= SRAM_DQ_in;
            if (state == HIGH && last)
                hi_buf <= SRAM_DQ_in;
            if (ready) begin
                WB_EN    <= WB_EN_in;
                MEM_R_EN <= MEM_R_EN_in;
                ALU_Res  <= ALU_Res_in;
                Dest     <= Dest_in;
                if (MEM_R_EN_in)
                    Mem_Data <= {hi_buf, lo_buf};
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - testbench for mem_stage_sram_ctrl with async SRAM model
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_Res_in, Val_Rm_in;
    logic [3:0]  Dest_in;
    logic        ready, WB_EN, MEM_R_EN;
    logic [31:0] ALU_Res, Mem_Data;
    logic [3:0]  Dest;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe, SRAM_WE_N;

    mem_stage_sram_ctrl dut (
        .clk(clk), .rst(rst),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_Res_in(ALU_Res_in), .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in),
        .ready(ready), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
        .ALU_Res(ALU_Res), .Mem_Data(Mem_Data), .Dest(Dest),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_DQ_in(SRAM_DQ_in), .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Async SRAM: write commits on the rising edge of WE_N; a reset-forced rise aborts it
    logic [15:0] sram [1024];
    logic [17:0] wa;
    logic [15:0] wd;
    assign SRAM_DQ_in = sram[SRAM_ADDR[9:0]];
    always @(negedge clk) if (SRAM_WE_N === 1'b0) begin wa = SRAM_ADDR; wd = SRAM_DQ_out; end
    always @(posedge SRAM_WE_N) if (rst === 1'b1) sram[wa[9:0]] = wd;

    logic [31:0] ref_mem [int];
    int          n_cmp = 0, n_err = 0;
    logic        exp_wb = 0, exp_mr = 0;
    logic [31:0] exp_alu = 0, exp_md = 0;
    logic [3:0]  exp_dest = 0;
    logic [17:0] s_addr [8];
    logic [15:0] s_dq [8];
    logic        s_we [8], s_oe [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] lo_of(input logic [31:0] alu);
        logic [31:0] h;
        h = ((alu - 32'd1024) >> 2) * 32'd2;
        return h[17:0];
    endfunction

    function automatic logic [31:0] ref_read(input logic [17:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    task automatic chk_memwb();
        chk("WB_EN", WB_EN, exp_wb);
        chk("MEM_R_EN", MEM_R_EN, exp_mr);
        chk("ALU_Res", ALU_Res, exp_alu);
        chk("Dest", Dest, exp_dest);
        chk("Mem_Data", Mem_Data, exp_md);
    endtask

    // Drive one op just after a rising edge, watch the freeze, then check the MEM/WB load
    task automatic do_op(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                         input logic [31:0] val, input logic [3:0] dest);
        int fr;
        logic rq, wr;
        logic [17:0] la;
        WB_EN_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
        ALU_Res_in = alu; Val_Rm_in = val; Dest_in = dest;
        rq = r | w; wr = w & ~r; la = lo_of(alu);
        fr = 0;
        @(negedge clk);
        while (ready !== 1'b1 && fr < 20) begin
            if (fr < 8) begin
                s_addr[fr] = SRAM_ADDR; s_dq[fr] = SRAM_DQ_out;
                s_we[fr] = SRAM_WE_N; s_oe[fr] = SRAM_DQ_oe;
            end
            fr++;
            @(negedge clk);
        end
        chk("frozen_cycles", fr, rq ? 5 : 0);
        if (rq && fr == 5) begin
            chk("detect_we_n", s_we[0], 1);
            chk("detect_oe", s_oe[0], 0);
            for (int i = 1; i < 5; i++) begin
                chk("sram_addr", s_addr[i], (i < 3) ? la : la + 18'd1);
                chk("we_n", s_we[i], wr ? ((i % 2) == 0) : 1);
                chk("dq_oe", s_oe[i], wr);
                if (wr) chk("dq_out", s_dq[i], (i < 3) ? val[15:0] : val[31:16]);
            end
        end
        chk("done_we_n", SRAM_WE_N, 1);
        chk("done_oe", SRAM_DQ_oe, 0);
        chk("done_addr", SRAM_ADDR, 0);
        if (wr) ref_mem[int'(la)] = val;
        if (r) exp_md = ref_read(la);
        exp_wb = wb; exp_mr = r; exp_alu = alu; exp_dest = dest;
        @(posedge clk);
        #1;
        chk_memwb();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0;
        WB_EN_in = $urandom; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_Res_in = $urandom; Val_Rm_in = $urandom; Dest_in = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk_memwb();
        chk("rst_we_n", SRAM_WE_N, 1);
        chk("rst_oe", SRAM_DQ_oe, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_dq_out", SRAM_DQ_out, 0);
        chk("rst_ready_idle", ready, 1);
        MEM_W_EN_in = 1; #1;
        chk("rst_ready_req", ready, 0);
        MEM_W_EN_in = 0; WB_EN_in = 0; ALU_Res_in = 0; Val_Rm_in = 0; Dest_in = 0;
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;

        do_op(0, 0, 1, 32'd1032, 32'h1234ABCD, 4'd0);
        chk("sram4", sram[4], 16'hABCD);
        chk("sram5", sram[5], 16'h1234);
        do_op(1, 1, 0, 32'd1032, 32'h0, 4'd7);
        do_op(1, 0, 0, 32'h55, $urandom, 4'd3);
        do_op(1, 1, 1, 32'd1032, 32'hFFFF0000, 4'd2);
        chk("both_sram4", sram[4], 16'hABCD);
        chk("both_sram5", sram[5], 16'h1234);
        do_op(0, 0, 1, 32'd0, 32'hCAFE5A5A, 4'd1);
        do_op(1, 1, 0, 32'd3, 32'h0, 4'd4);

        WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 1;
        ALU_Res_in = 32'd1032; Val_Rm_in = 32'hDEADBEEF; Dest_in = 4'd1;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        #1;
        exp_wb = 0; exp_mr = 0; exp_alu = 0; exp_dest = 0; exp_md = 0;
        chk_memwb();
        chk("abort_we_n", SRAM_WE_N, 1);
        chk("abort_oe", SRAM_DQ_oe, 0);
        chk("abort_addr", SRAM_ADDR, 0);
        chk("abort_ready", ready, 0);
        MEM_W_EN_in = 0; #1;
        chk("abort_ready_idle", ready, 1);
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1;
        chk("abort_sram5", sram[5], 16'h1234);
        chk("abort_sram4", sram[4], 16'hBEEF);
        ref_mem[4] = 32'h1234BEEF;
        do_op(1, 1, 0, 32'd1032, 32'h0, 4'd9);

        for (int n = 0; n < 40; n++) begin
            int kind;
            logic [31:0] alu;
            kind = $urandom_range(0, 3);
            alu = 32'd1024 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            case (kind)
                0: do_op(1'($urandom), 0, 0, $urandom, $urandom, 4'($urandom));
                1: do_op(1'($urandom), 0, 1, alu, $urandom, 4'($urandom));
                2: do_op(1'($urandom), 1, 0, alu, $urandom, 4'($urandom));
                default: do_op(1'($urandom), 1, 1, alu, $urandom, 4'($urandom));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
